// File: rtl/hazard_pkg.sv
// Shared encodings for the scoreboarded hazard controller: forward selects,
// divider FSM states and a per-stage control bundle.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  // One bit per pipeline stage; used for both the stall and the flush vector.
  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stage_ctl_t;

  localparam stage_ctl_t STAGE_NONE = '{f: 1'b0, d: 1'b0, e: 1'b0, m: 1'b0, w: 1'b0};

endpackage

// File: rtl/hazard_div_fsm.sv
// Divider occupancy tracker: holds the E stage for exactly DIV_LAT cycles per
// divide and parks in DONE until the result is allowed to leave E.
module hazard_div_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic div_startE,
  input  logic stallE,
  input  logic flushE,
  input  logic abort,
  output logic div_stall,
  output logic div_busy
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 2);

  div_state_t    state;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      div_busy <= 1'b0;
    end else if (abort) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      div_busy <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_startE && !flushE) begin
            state    <= DIV_BUSY;
            cnt      <= CNT_LOAD;
            div_busy <= 1'b1;
          end
        end
        DIV_BUSY: begin
          if (cnt == '0) begin
            state <= DIV_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV_DONE: begin
          // Result is held until E is free to advance (e.g. memwait ends).
          if (!stallE) begin
            state    <= DIV_IDLE;
            div_busy <= 1'b0;
          end
        end
        default: begin
          state    <= DIV_IDLE;
          cnt      <= '0;
          div_busy <= 1'b0;
        end
      endcase
    end
  end

  // The start cycle itself stalls, then DIV_LAT-1 BUSY cycles follow.
  assign div_stall = ((state == DIV_IDLE) && div_startE) || (state == DIV_BUSY);

endmodule

// File: rtl/hazard_sb.sv
// Scoreboarded hazard controller for the 5-stage pipeline: forwarding, load /
// branch interlocks, memory handshake waits, divider occupancy and redirects.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int DIV_LAT = 36
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic          branchD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] writeregE,
  input  logic          regwriteE,
  input  logic          memtoregE,
  input  logic          div_startE,
  input  logic [AW-1:0] writeregM,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic          write_hiloM,
  input  logic          jumpM,
  input  logic          pcsrcM,
  input  logic          excM,
  input  logic          dmem_reqM,
  input  logic          dmem_readyM,
  input  logic          imem_readyF,
  input  logic [AW-1:0] writeregW,
  input  logic          regwriteW,
  output logic          forwardaD,
  output logic          forwardbD,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          forward_hilo_E,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          stallW,
  output logic          flushF,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic          flushW,
  output logic          div_busy
);

  function automatic fwd_sel_t fwd_e(input logic [AW-1:0] src,
                                     input logic [AW-1:0] wr_m, input logic we_m,
                                     input logic [AW-1:0] wr_w, input logic we_w);
    if (src != '0 && we_m && src == wr_m) return FWD_M;
    if (src != '0 && we_w && src == wr_w) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic hits(input logic [AW-1:0] dst,
                                input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (dst != '0) && (dst == a || dst == b);
  endfunction

  logic       lwstall, brstall, memwait, redirect;
  logic       div_stall, div_abort, redir_pend;
  stage_ctl_t stall, flush;

  assign forwardaD      = (rsD != '0) && regwriteM && (rsD == writeregM);
  assign forwardbD      = (rtD != '0) && regwriteM && (rtD == writeregM);
  assign forwardaE      = fwd_e(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardbE      = fwd_e(rtE, writeregM, regwriteM, writeregW, regwriteW);
  assign forward_hilo_E = write_hiloM;

  assign lwstall  = memtoregE && (rtE != '0) && (rtE == rsD || rtE == rtD);
  assign brstall  = branchD && ((regwriteE && hits(writeregE, rsD, rtD)) ||
                                (memtoregM && hits(writeregM, rsD, rtD)));
  assign memwait  = dmem_reqM && !dmem_readyM;
  assign redirect = jumpM || pcsrcM || excM;

  // NOTE: both vectors get a default before the priority chain so no path
  // through the block leaves them unassigned (which would infer latches).
  always_comb begin
    stall = STAGE_NONE;
    flush = STAGE_NONE;
    if (redirect) begin
      flush.f = 1'b1;
      flush.d = 1'b1;
      flush.e = 1'b1;
      flush.m = excM;
      stall.f = !imem_readyF;
    end else if (memwait) begin
      stall.f = 1'b1;
      stall.d = 1'b1;
      stall.e = 1'b1;
      stall.m = 1'b1;
      flush.w = 1'b1;
    end else if (div_stall) begin
      stall.f = 1'b1;
      stall.d = 1'b1;
      stall.e = 1'b1;
      flush.m = 1'b1;
    end else if (lwstall || brstall) begin
      stall.f = 1'b1;
      stall.d = 1'b1;
      flush.e = 1'b1;
    end else if (!imem_readyF) begin
      stall.f = 1'b1;
      flush.d = 1'b1;
    end
    // First valid fetch after a deferred redirect is still wrong-path.
    if (redir_pend && imem_readyF) flush.d = 1'b1;
  end

  assign {stallF, stallD, stallE, stallM, stallW} = {stall.f, stall.d, stall.e, stall.m, 1'b0};
  assign {flushF, flushD, flushE, flushM, flushW} = {flush.f, flush.d, flush.e, flush.m, flush.w};

  assign div_abort = excM || (flush.e && div_busy);

  hazard_div_fsm #(
    .DIV_LAT (DIV_LAT)
  ) u_div_fsm (
    .clk        (clk),
    .rst        (rst),
    .div_startE (div_startE),
    .stallE     (stall.e),
    .flushE     (flush.e),
    .abort      (div_abort),
    .div_stall  (div_stall),
    .div_busy   (div_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_pend <= 1'b0;
    end else if (redirect && !imem_readyF) begin
      redir_pend <= 1'b1;
    end else if (imem_readyF) begin
      redir_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_sb.sv
// Randomized scoreboard bench for hazard_sb against a cycle-level reference
// model built from the hazard rules, plus directed pipeline scenarios.
module tb_hazard_sb;

  localparam int AW      = 5;
  localparam int DIV_LAT = 4;

  typedef struct packed {
    logic [AW-1:0] rsD, rtD;
    logic          branchD;
    logic [AW-1:0] rsE, rtE, writeregE;
    logic          regwriteE, memtoregE, div_startE;
    logic [AW-1:0] writeregM;
    logic          regwriteM, memtoregM, write_hiloM, jumpM, pcsrcM, excM;
    logic          dmem_reqM, dmem_readyM, imem_readyF;
    logic [AW-1:0] writeregW;
    logic          regwriteW;
  } in_t;

  // stall/flush bit order: [4]=F [3]=D [2]=E [1]=M [0]=W
  typedef struct packed {
    logic       fad, fbd;
    logic [1:0] fae, fbe;
    logic       fhilo;
    logic [4:0] stall;
    logic [4:0] flush;
    logic       busy;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  vin;

  logic       forwardaD, forwardbD, forward_hilo_E, div_busy;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushF, flushD, flushE, flushM, flushW;

  int   n_vec = 0;
  int   n_err = 0;
  int   vec_id = 0;
  out_t exp_q[$];
  int   id_q[$];

  // Reference state: div_age < 0 is idle, 1..DIV_LAT-1 occupied, DIV_LAT done.
  int   cur_age = -1, nxt_age = -1;
  bit   cur_pend = 1'b0, nxt_pend = 1'b0;

  always #5 clk = ~clk;

  hazard_sb #(.AW(AW), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .rsD(vin.rsD), .rtD(vin.rtD), .branchD(vin.branchD),
    .rsE(vin.rsE), .rtE(vin.rtE), .writeregE(vin.writeregE),
    .regwriteE(vin.regwriteE), .memtoregE(vin.memtoregE), .div_startE(vin.div_startE),
    .writeregM(vin.writeregM), .regwriteM(vin.regwriteM), .memtoregM(vin.memtoregM),
    .write_hiloM(vin.write_hiloM), .jumpM(vin.jumpM), .pcsrcM(vin.pcsrcM), .excM(vin.excM),
    .dmem_reqM(vin.dmem_reqM), .dmem_readyM(vin.dmem_readyM), .imem_readyF(vin.imem_readyF),
    .writeregW(vin.writeregW), .regwriteW(vin.regwriteW),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .forward_hilo_E(forward_hilo_E),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_busy(div_busy)
  );

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] src, input in_t v);
    if (src != 0 && v.regwriteM && src == v.writeregM) return 2'b10;
    if (src != 0 && v.regwriteW && src == v.writeregW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model(input in_t v, input int age, input bit pend);
    out_t o;
    bit   lw, br, mw, rd, dstall;
    o       = '0;
    o.fad   = v.rsD != 0 && v.regwriteM && v.rsD == v.writeregM;
    o.fbd   = v.rtD != 0 && v.regwriteM && v.rtD == v.writeregM;
    o.fae   = fwd_ref(v.rsE, v);
    o.fbe   = fwd_ref(v.rtE, v);
    o.fhilo = v.write_hiloM;
    lw = v.memtoregE && v.rtE != 0 && (v.rtE == v.rsD || v.rtE == v.rtD);
    br = v.branchD &&
         ((v.regwriteE && v.writeregE != 0 && (v.writeregE == v.rsD || v.writeregE == v.rtD)) ||
          (v.memtoregM && v.writeregM != 0 && (v.writeregM == v.rsD || v.writeregM == v.rtD)));
    mw = v.dmem_reqM && !v.dmem_readyM;
    rd = v.jumpM || v.pcsrcM || v.excM;
    dstall = (age < 0 && v.div_startE) || (age >= 1 && age < DIV_LAT);
    if (rd) begin
      o.flush = {3'b111, v.excM, 1'b0};
      o.stall = {!v.imem_readyF, 4'b0000};
    end else if (mw) begin
      o.stall = 5'b11110; o.flush = 5'b00001;
    end else if (dstall) begin
      o.stall = 5'b11100; o.flush = 5'b00010;
    end else if (lw || br) begin
      o.stall = 5'b11000; o.flush = 5'b00100;
    end else if (!v.imem_readyF) begin
      o.stall = 5'b10000; o.flush = 5'b01000;
    end
    if (pend && v.imem_readyF) o.flush[3] = 1'b1;
    o.busy = age >= 0;
    return o;
  endfunction

  // Drives one cycle of inputs just after the edge and queues the expected outputs.
  task automatic apply(input in_t v, input logic r);
    out_t o;
    @(posedge clk);
    #1;
    cur_age  = nxt_age;
    cur_pend = nxt_pend;
    vin = v;
    rst = r;
    if (r) begin
      cur_age  = -1;
      cur_pend = 1'b0;
    end
    o = model(v, cur_age, cur_pend);
    exp_q.push_back(o);
    id_q.push_back(vec_id);
    vec_id++;
    if (r) begin
      nxt_age = -1;
    end else if (v.excM || (o.flush[2] && cur_age >= 0)) begin
      nxt_age = -1;
    end else if (cur_age < 0) begin
      nxt_age = (v.div_startE && !o.flush[2]) ? 1 : -1;
    end else if (cur_age < DIV_LAT) begin
      nxt_age = cur_age + 1;
    end else begin
      nxt_age = o.stall[2] ? cur_age : -1;
    end
    if (r) nxt_pend = 1'b0;
    else if ((v.jumpM || v.pcsrcM || v.excM) && !v.imem_readyF) nxt_pend = 1'b1;
    else if (v.imem_readyF) nxt_pend = 1'b0;
    else nxt_pend = cur_pend;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response.
  always @(negedge clk) begin
    out_t act, e;
    int   id;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      act = {forwardaD, forwardbD, forwardaE, forwardbE, forward_hilo_E,
             stallF, stallD, stallE, stallM, stallW,
             flushF, flushD, flushE, flushM, flushW, div_busy};
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL vec%0d outputs: got %h, required %h", id, act, e);
      end
    end
  end

  function automatic in_t base();
    in_t v = '0;
    v.imem_readyF = 1'b1;
    return v;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.rsD = AW'($urandom_range(0, 3));        v.rtD = AW'($urandom_range(0, 3));
    v.rsE = AW'($urandom_range(0, 3));        v.rtE = AW'($urandom_range(0, 3));
    v.writeregE = AW'($urandom_range(0, 3));  v.writeregM = AW'($urandom_range(0, 3));
    v.writeregW = AW'($urandom_range(0, 3));
    v.branchD     = $urandom_range(0, 3) == 0;
    v.regwriteE   = $urandom_range(0, 1) == 0;
    v.memtoregE   = $urandom_range(0, 3) == 0;
    v.div_startE  = $urandom_range(0, 3) == 0;
    v.regwriteM   = $urandom_range(0, 1) == 0;
    v.memtoregM   = $urandom_range(0, 3) == 0;
    v.write_hiloM = $urandom_range(0, 3) == 0;
    v.jumpM       = $urandom_range(0, 31) == 0;
    v.pcsrcM      = $urandom_range(0, 31) == 0;
    v.excM        = $urandom_range(0, 31) == 0;
    v.dmem_reqM   = $urandom_range(0, 3) == 0;
    v.dmem_readyM = $urandom_range(0, 1) == 0;
    v.imem_readyF = $urandom_range(0, 3) != 0;
    v.regwriteW   = $urandom_range(0, 1) == 0;
    return v;
  endfunction

  initial begin
    in_t v;
    int  cnt;
    vin = base();

    apply(base(), 1'b1);
    apply(base(), 1'b1);
    apply(base(), 1'b0);

    // Forwarding: M beats W; register 0 never forwards.
    v = base();
    v.rsE = 3; v.writeregM = 3; v.regwriteM = 1; v.writeregW = 3; v.regwriteW = 1;
    apply(v, 1'b0);
    @(negedge clk); #1; check("fwd_m_priority", forwardaE, 2);
    v.rsE = 0;
    apply(v, 1'b0);
    @(negedge clk); #1; check("fwd_reg0", forwardaE, 0);

    // lw $5 in E, add $6,$5 in D: one bubble, then W forwards.
    v = base();
    v.memtoregE = 1; v.regwriteE = 1; v.rtE = 5; v.writeregE = 5; v.rsD = 5; v.rtD = 1;
    apply(v, 1'b0);
    @(negedge clk); #1; check("lw_stall", {stallF, stallD, flushE}, 3'b111);
    v = base();
    v.rsD = 5; v.rtD = 1; v.memtoregM = 1; v.regwriteM = 1; v.writeregM = 5;
    apply(v, 1'b0);
    @(negedge clk); #1; check("lw_release", {stallF, stallD, flushE}, 3'b000);
    v = base();
    v.rsE = 5; v.rtE = 1; v.regwriteW = 1; v.writeregW = 5;
    apply(v, 1'b0);
    @(negedge clk); #1; check("lw_fwd_w", forwardaE, 1);

    // Divide with start held while stalled: exactly DIV_LAT stall cycles.
    cnt = 0;
    v = base(); v.div_startE = 1;
    for (int i = 0; i < DIV_LAT + 1; i++) begin
      apply(v, 1'b0);
      @(negedge clk); #1;
      if (stallE) cnt++;
    end
    check("div_stall_cycles", cnt, DIV_LAT);
    apply(base(), 1'b0);
    apply(base(), 1'b0);

    // Exception in the 2nd BUSY cycle aborts the divider.
    v = base(); v.div_startE = 1;
    apply(v, 1'b0);
    apply(v, 1'b0);
    v.excM = 1;
    apply(v, 1'b0);
    apply(base(), 1'b0);
    @(negedge clk); #1; check("exc_abort_busy", div_busy, 0);
    check("exc_abort_stalls", {stallF, stallD, stallE, stallM}, 0);

    // Memory wait during BUSY: three stallM cycles, divider unaffected.
    cnt = 0;
    v = base(); v.div_startE = 1;
    apply(v, 1'b0);
    apply(v, 1'b0);
    v.dmem_reqM = 1;
    for (int i = 0; i < 3; i++) begin
      apply(v, 1'b0);
      @(negedge clk); #1;
      if (stallM && flushW) cnt++;
    end
    v.dmem_reqM = 0;
    for (int i = 0; i < DIV_LAT; i++) apply(v, 1'b0);
    @(negedge clk); #1;
    check("memwait_cycles", cnt, 3);
    apply(base(), 1'b0);
    apply(base(), 1'b0);

    // Redirect while fetch is stalled: discard the first valid fetch.
    v = base(); v.pcsrcM = 1; v.imem_readyF = 0;
    apply(v, 1'b0);
    v = base(); v.imem_readyF = 0;
    apply(v, 1'b0);
    apply(v, 1'b0);
    apply(base(), 1'b0);
    @(negedge clk); #1; check("redir_flushD", flushD, 1);
    apply(base(), 1'b0);
    @(negedge clk); #1; check("redir_cleared", flushD, 0);

    // Asynchronous reset mid-divide clears state before the next edge.
    v = base(); v.div_startE = 1;
    apply(v, 1'b0);
    apply(v, 1'b0);
    apply(base(), 1'b1);
    @(negedge clk); #1; check("rst_async_busy", div_busy, 0);
    check("rst_outputs", {stallF, stallD, stallE, stallM, stallW,
                          flushF, flushD, flushE, flushM, flushW}, 0);
    apply(base(), 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      apply(rand_in(), ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    apply(base(), 1'b0);

    @(negedge clk); #1;
    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
